// File: rtl/vit_mem_pkg.sv
// rtl/vit_mem_pkg.sv - shared defaults, FSM state type and matrix type for the matrix loaders
package vit_mem_pkg;

  localparam int DIM_DEF = 32;
  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default-sized matrix, shared with the output_flatten consumers
  typedef logic signed [DIM_DEF-1:0][DIM_DEF-1:0][DW_DEF-1:0] matrix_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// rtl/rd_valid_pipe.sv - RD_LAT-deep delay line aligning read strobes with returned data
module rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic in,
  output logic out
);

  logic [RD_LAT-1:0] sr_q;

  // Shift the strobe one stage per cycle; reset drops any in-flight reads
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= in;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign out = sr_q[RD_LAT-1];

endmodule

// File: rtl/matrix_unflatten.sv
// rtl/matrix_unflatten.sv - loads a DIM x DIM matrix from flat memory; MATRIX_UNFLATTEN_TRANSPOSE_EN loads it transposed
module matrix_unflatten
  import vit_mem_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [AW-1:0]                         i_base_addr,
  output logic                                  rd_en,
  output logic [AW-1:0]                         rd_addr,
  input  logic signed [DW-1:0]                  rd_data,
  output logic signed [DIM-1:0][DIM-1:0][DW-1:0] o_matrix,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_valid
);

  localparam int              LW   = $clog2(DIM);
  localparam int              IW   = 2 * LW;
  localparam logic [IW-1:0]   LAST = IW'(DIM * DIM - 1);

  state_t                                 state_q, state_d;
  logic [AW-1:0]                          base_q;
  logic [IW-1:0]                          issue_q;
  logic [IW-1:0]                          cap_idx_q;
  logic                                   valid_q;
  logic signed [DIM-1:0][DIM-1:0][DW-1:0] matrix_q;
  logic                                   accept;
  logic                                   pipe_out;
  logic                                   cap_en;
  logic [LW-1:0]                          cap_row;
  logic [LW-1:0]                          cap_col;

  rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .in    (rd_en),
    .out   (pipe_out)
  );

`ifdef MATRIX_UNFLATTEN_TRANSPOSE_EN
  assign cap_row = cap_idx_q[LW-1:0];
  assign cap_col = cap_idx_q[IW-1:LW];
`else
  assign cap_row = cap_idx_q[IW-1:LW];
  assign cap_col = cap_idx_q[LW-1:0];
`endif

  assign rd_addr  = base_q + AW'(issue_q);
  assign o_matrix = matrix_q;
  assign o_valid  = valid_q;

  // Next-state and strobe decode; returning data is only accepted during a load
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    accept  = 1'b0;
    cap_en  = pipe_out && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (issue_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_en && (cap_idx_q == LAST)) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, base address, issue/capture counters and the valid flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      issue_q   <= '0;
      cap_idx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q    <= i_base_addr;
        issue_q   <= '0;
        cap_idx_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        if (rd_en)  issue_q   <= issue_q + 1'b1;
        if (cap_en) cap_idx_q <= cap_idx_q + 1'b1;
        if (state_q == DONE) valid_q <= 1'b1;
      end
    end
  end

  // Write each returned word into its element; untouched elements keep old values
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      matrix_q <= '0;
    end else if (cap_en) begin
      matrix_q[cap_row][cap_col] <= rd_data;
    end
  end

endmodule

// File: tb/tb_matrix_unflatten.sv
// tb/tb_matrix_unflatten.sv - directed bench for matrix_unflatten at RD_LAT 1 and 3 (honours MATRIX_UNFLATTEN_TRANSPOSE_EN)
module tb_matrix_unflatten;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        neg = 1'b0;
  logic [9:0]  base_addr = '0;

  logic                             rd_en1, busy1, done1, valid1;
  logic [9:0]                       rd_addr1;
  logic signed [31:0]               rd_data1;
  logic signed [31:0][31:0][31:0]   mat1;

  logic                             rd_en3, busy3, done3, valid3;
  logic [9:0]                       rd_addr3, a1_q, a2_q;
  logic signed [31:0]               rd_data3;
  logic signed [31:0][31:0][31:0]   mat3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_unflatten #(.DIM(32), .DW(32), .AW(10), .RD_LAT(1)) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start & ~sel),
    .i_base_addr (base_addr),
    .rd_en       (rd_en1),
    .rd_addr     (rd_addr1),
    .rd_data     (rd_data1),
    .o_matrix    (mat1),
    .o_busy      (busy1),
    .o_done      (done1),
    .o_valid     (valid1)
  );

  matrix_unflatten #(.DIM(32), .DW(32), .AW(10), .RD_LAT(3)) u_dut3 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start & sel),
    .i_base_addr (base_addr),
    .rd_en       (rd_en3),
    .rd_addr     (rd_addr3),
    .rd_data     (rd_data3),
    .o_matrix    (mat3),
    .o_busy      (busy3),
    .o_done      (done3),
    .o_valid     (valid3)
  );

  function automatic logic signed [31:0] mem_f(input logic [9:0] a);
    return neg ? -$signed({22'd0, a}) : $signed({22'd0, a});
  endfunction

  always @(posedge clk) rd_data1 <= mem_f(rd_addr1);

  always @(posedge clk) begin
    a1_q     <= rd_addr3;
    a2_q     <= a1_q;
    rd_data3 <= mem_f(a2_q);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_elem(input int r, input int c, input int base, input bit ng);
    int k;
    int a;
`ifdef MATRIX_UNFLATTEN_TRANSPOSE_EN
    k = c * 32 + r;
`else
    k = r * 32 + c;
`endif
    a = (base + k) % 1024;
    return ng ? -longint'(a) : longint'(a);
  endfunction

  function automatic longint obs_elem(input bit s, input int r, input int c);
    logic [31:0] w;
    w = s ? mat3[r][c] : mat1[r][c];
    return longint'($signed(w));
  endfunction

  function automatic int count_bad(input bit s, input int base, input bit ng);
    int bad = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (obs_elem(s, r, c) !== exp_elem(r, c, base, ng)) bad++;
    return bad;
  endfunction

  function automatic int count_nonzero(input bit s);
    int nz = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (obs_elem(s, r, c) != 0) nz++;
    return nz;
  endfunction

  task automatic load(input bit s, input int base, input bit ng, input int glitch, input int rst_at,
                      output int done_cyc, output int rd_cnt, output int addr_err, output int vrises);
    logic prev_v;
    logic o_rd, o_dn, o_v;
    logic [9:0] o_ad;
    done_cyc = 0; rd_cnt = 0; addr_err = 0; vrises = 0; prev_v = 1'b0;
    @(negedge clk);
    sel = s; neg = ng; base_addr = 10'(base); start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 1100; n++) begin
      #1;
      if (n == 1) start = 1'b0;
      if (n == glitch) start = 1'b1;
      else if (n == glitch + 1) start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        break;
      end
      o_rd = s ? rd_en3 : rd_en1;
      o_ad = s ? rd_addr3 : rd_addr1;
      o_dn = s ? done3 : done1;
      o_v  = s ? valid3 : valid1;
      if (o_rd) begin
        if (int'(o_ad) != (base + rd_cnt) % 1024) addr_err++;
        rd_cnt++;
      end
      if (o_v && !prev_v) vrises++;
      prev_v = o_v;
      if (o_dn && done_cyc == 0) done_cyc = n;
      if (done_cyc != 0 && n >= done_cyc + 2) break;
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, rc, ae, vr;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_valid", valid1, 0);
    check("rst_rd_en", rd_en1, 0);
    check("rst_rd_addr", rd_addr1, 0);
    check("rst_matrix_nonzero", count_nonzero(0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Load A: base 0, mem[a]=a, RD_LAT 1
    load(0, 0, 0, -1, -1, dc, rc, ae, vr);
    check("A_done_cycle", dc, 1026);
    check("A_rd_en_count", rc, 1024);
    check("A_addr_errors", ae, 0);
    check("A_valid_rises", vr, 1);
    check("A_matrix_bad", count_bad(0, 0, 0), 0);
`ifdef MATRIX_UNFLATTEN_TRANSPOSE_EN
    check("A_m1_2", obs_elem(0, 1, 2), 65);
`else
    check("A_m1_2", obs_elem(0, 1, 2), 34);
`endif
    check("A_m31_31", obs_elem(0, 31, 31), 1023);
    check("A_valid_after", valid1, 1);
    check("A_busy_after", busy1, 0);
    check("A_done_after", done1, 0);

    // Load B: base 1000, address wraps past 1023
    load(0, 1000, 0, -1, -1, dc, rc, ae, vr);
    check("B_done_cycle", dc, 1026);
    check("B_addr_errors", ae, 0);
    check("B_rd_en_count", rc, 1024);
`ifndef MATRIX_UNFLATTEN_TRANSPOSE_EN
    check("B_m0_24", obs_elem(0, 0, 24), 0);
`else
    check("B_m0_24", obs_elem(0, 0, 24), 744);
`endif
    check("B_matrix_bad", count_bad(0, 1000, 0), 0);

    // Load C: RD_LAT 3, mem[a]=-a
    load(1, 0, 1, -1, -1, dc, rc, ae, vr);
    check("C_done_cycle", dc, 1028);
    check("C_rd_en_count", rc, 1024);
    check("C_m31_31", obs_elem(1, 31, 31), -1023);
    check("C_matrix_bad", count_bad(1, 0, 1), 0);
    check("C_valid_after", valid3, 1);

    // Load D: start pulsed mid-load must be ignored
    load(0, 0, 0, 500, -1, dc, rc, ae, vr);
    check("D_done_cycle", dc, 1026);
    check("D_valid_rises", vr, 1);
    check("D_rd_en_count", rc, 1024);
    check("D_matrix_bad", count_bad(0, 0, 0), 0);
    check("D_busy_after", busy1, 0);

    // Reset at cycle 300 of a load with mem[a]=-a
    load(0, 0, 1, -1, 300, dc, rc, ae, vr);
    @(posedge clk);
    #1;
    check("R_busy", busy1, 0);
    check("R_rd_en", rd_en1, 0);
    check("R_rd_addr", rd_addr1, 0);
    check("R_valid", valid1, 0);
    check("R_done", done1, 0);
    check("R_matrix_nonzero", count_nonzero(0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("R_idle_nonzero", count_nonzero(0), 0);
    check("R_idle_busy", busy1, 0);

    // Load E after reset: clean load, no leftovers
    load(0, 0, 0, -1, -1, dc, rc, ae, vr);
    check("E_done_cycle", dc, 1026);
    check("E_matrix_bad", count_bad(0, 0, 0), 0);
    check("E_valid_after", valid1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_unflatten.md
MATRIX_UNFLATTEN -- requirements
Module: matrix_unflatten

Interface
REQ-001 SHALL have parameter DIM, default 32, matrix rows and columns (power of two).
REQ-002 SHALL have parameter DW, default 32, signed element width in bits.
REQ-003 SHALL have parameter AW, default 10, memory address width; AW SHALL be at least 2*log2(DIM).
REQ-004 SHALL have parameter RD_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-005 SHALL have port i_clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port i_start, input, 1, request to load one matrix.
REQ-008 SHALL have port i_base_addr, input, AW, flat address of element (0,0); sampled when start is accepted.
REQ-009 SHALL have port rd_en, output, 1, memory read strobe.
REQ-010 SHALL have port rd_addr, output, AW, memory read address.
REQ-011 SHALL have port rd_data, input, signed DW, memory data, valid RD_LAT cycles after rd_en.
REQ-012 SHALL have port o_matrix, output, signed [DIM][DIM][DW], assembled matrix.
REQ-013 SHALL have port o_busy, output, 1, high while a load is in progress.
REQ-014 SHALL have port o_done, output, 1, one-cycle pulse when the load completes.
REQ-015 SHALL have port o_valid, output, 1, o_matrix holds a complete load.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE: i_start=1 SHALL be accepted, latch i_base_addr, clear the issue and capture counters, clear o_valid, and go to READ.
REQ-018 READ: SHALL assert rd_en with rd_addr=(base+issue_idx) mod 2^AW each cycle, incrementing issue_idx 0..DIM*DIM-1; after index DIM*DIM-1 SHALL go to DRAIN.
REQ-019 SHALL delay rd_en through an RD_LAT-deep valid shift register; each delayed valid SHALL write rd_data into element cap_idx and increment cap_idx.
REQ-020 Element cap_idx k SHALL map to row k/DIM, column k%DIM (index upper/lower bit fields).
REQ-021 DRAIN: rd_en=0; when the final capture (k=DIM*DIM-1) occurs SHALL go to DONE.
REQ-022 DONE: SHALL assert o_done for exactly one cycle, set o_valid=1, and return to IDLE.
REQ-023 Timing: start accepted at cycle 0 SHALL produce first rd_en at cycle 1, last rd_en at cycle DIM*DIM, and o_done at cycle DIM*DIM+RD_LAT+1.
REQ-024 o_busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-025 i_start while o_busy=1 SHALL be ignored without side effects.
REQ-026 Address SHALL wrap modulo 2^AW with no error indication.
REQ-027 o_valid SHALL stay 1 after o_done until the next accepted start; o_matrix SHALL be stable while o_valid=1.
REQ-028 Elements not yet captured during a load SHALL retain their previous values.

Reset
REQ-029 On i_rst: state=IDLE, rd_en=0, rd_addr=0, o_busy=0, o_done=0, o_valid=0, counters, valid pipe and o_matrix all zero.
REQ-030 Reset mid-load SHALL abort immediately; in-flight read data arriving after reset SHALL be discarded.

Configuration
REQ-031 Macro MATRIX_UNFLATTEN_TRANSPOSE_EN defined: element k SHALL map to row k%DIM, column k/DIM (load transposed).
REQ-032 Macro undefined: mapping per REQ-020 only; no transpose logic present.

Structure
REQ-033 Shared package vit_mem_pkg SHALL hold DIM/DW/AW defaults, a state enum typedef, and the matrix typedef reused by output_flatten consumers.
REQ-034 The RD_LAT valid delay line SHALL be sub-module rd_valid_pipe (parameter RD_LAT, ports i_clk, i_rst, in, out).
REQ-035 Address generation, FSM and capture SHALL remain in matrix_unflatten.

Verification
REQ-036 Memory model preloaded mem[a]=a, base=0, RD_LAT=1, start -> o_matrix[r][c]=32r+c; o_done at cycle 1026; exactly 1024 rd_en cycles.
REQ-037 base=1000 with AW=10 -> rd_addr sequence 1000..1023, 0..999; o_matrix[0][24]=0.
REQ-038 RD_LAT=3 with signed data mem[a]=-a -> o_matrix[31][31]=-1023; o_done at cycle 1028.
REQ-039 i_start pulsed at cycle 500 of a load -> no restart; o_done still at cycle 1026; o_valid rises once.
REQ-040 i_rst asserted at cycle 300 -> all outputs zero next edge; new start loads cleanly with no stale captures.
REQ-041 MATRIX_UNFLATTEN_TRANSPOSE_EN defined, mem[a]=a -> o_matrix[r][c]=32c+r.
